// File: rtl/led_display_pkg.sv
// Shared types and helpers for the LED matrix row driver.
package led_display_pkg;

  typedef enum logic [1:0] {
    SS_IDLE,
    SS_SHIFT,
    SS_LATCH
  } state_t;

  localparam int unsigned CH_R   = 0;
  localparam int unsigned CH_G   = 1;
  localparam int unsigned CH_B   = 2;
  localparam int unsigned NUM_CH = 3;

  // System clocks per bit-clock half period.
  function automatic int unsigned half_count(input int unsigned sys_freq,
                                             input int unsigned write_freq);
    return sys_freq / (2 * write_freq);
  endfunction

endpackage

// File: rtl/led_matrix_row_driver_if.sv
// Pixel valid/ready handshake between the frame-buffer controller and the row driver.
interface led_matrix_row_driver_if #(
  parameter int unsigned PIXEL_W = 48
) ();

  logic               pixel_valid_in;
  logic               pixel_ready_out;
  logic [PIXEL_W-1:0] pixel_in;

  modport master (output pixel_valid_in, output pixel_in, input pixel_ready_out);
  modport slave  (input pixel_valid_in, input pixel_in, output pixel_ready_out);

endinterface

// File: rtl/led_bit_clk_gen.sv
// Panel bit-clock generator: low HALF cycles then high HALF cycles while run is high,
// held at phase zero otherwise so every pixel starts aligned.
module led_bit_clk_gen #(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = $clog2(HALF + 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = run && (cnt == CNT_W'(HALF - 1));
  assign rise_c = wrap_c && !bclk;
  assign fall_c = wrap_c && bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (wrap_c) begin
      cnt  <= '0;
      bclk <= !bclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_matrix_row_driver.sv
// HUB75-style bit-serial pixel driver: one pixel per handshake, channels shifted MSB-first.
// Define LED_DRV_LATCH_EN to close each row with a latch pulse and row-address advance.
module led_matrix_row_driver
  import led_display_pkg::*;
#(
  parameter int unsigned WRITE_FREQ   = 1_000_000,
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned COLOR_DEPTH  = 8,
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned ROW_PIXELS   = 64,
  parameter int unsigned NUM_ROWS     = 16,
  parameter int unsigned LATCH_CYCLES = 4,
  localparam int unsigned ADDR_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                        clk_in,
  input  logic                        n_reset_in,
  input  logic                        enable_in,
  led_matrix_row_driver_if.slave      pix,
  output logic [NUM_LANES*NUM_CH-1:0] rgb_out,
  output logic                        bit_clk_out,
  output logic                        latch_out,
  output logic [ADDR_W-1:0]           row_addr_out,
  output logic                        row_done_out
);

  localparam int unsigned HALF  = half_count(SYS_CLK_FREQ, WRITE_FREQ);
  localparam int unsigned BIT_W = $clog2(COLOR_DEPTH + 1);
  localparam int unsigned PIX_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;

  if (HALF < 2) begin : g_half_chk
    $error("led_matrix_row_driver: SYS_CLK_FREQ/(2*WRITE_FREQ) must be at least 2");
  end
  if (LATCH_CYCLES < 1) begin : g_latch_chk
    $error("led_matrix_row_driver: LATCH_CYCLES must be at least 1");
  end

  state_t           state, state_nx;
  logic             started;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [PIX_W-1:0] pix_cnt, pix_cnt_nx;
  logic             accept_c, row_end_c, fall_c, rise_unused_c;

  // Ready is held off until the first clock after reset so reset drives every output low.
  assign pix.pixel_ready_out = started && enable_in && (state == SS_IDLE);
  assign accept_c            = pix.pixel_valid_in && pix.pixel_ready_out;
  assign row_end_c           = (pix_cnt == PIX_W'(ROW_PIXELS - 1));

  led_bit_clk_gen #(.HALF(HALF)) u_bclk (
    .clk    (clk_in),
    .rst_n  (n_reset_in),
    .run    (state == SS_SHIFT),
    .bclk   (bit_clk_out),
    .rise_c (rise_unused_c),
    .fall_c (fall_c)
  );

  // Channel shift registers; zero-fill leaves them clear outside SHIFT.
  for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
    for (genvar c = int'(CH_R); c <= int'(CH_B); c++) begin : g_chan
      localparam int unsigned IDX = l * NUM_CH + c;
      logic [COLOR_DEPTH-1:0] sr;

      always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
          sr <= '0;
        end else if (accept_c) begin
          sr <= pix.pixel_in[IDX*COLOR_DEPTH +: COLOR_DEPTH];
        end else if (fall_c) begin
          sr <= sr << 1;
        end
      end

      assign rgb_out[IDX] = sr[COLOR_DEPTH-1];
    end
  end

`ifdef LED_DRV_LATCH_EN
  localparam int unsigned LAT_W = $clog2(LATCH_CYCLES + 1);

  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
  logic [ADDR_W-1:0] row_addr_nx;
  logic              row_done_nx;
`endif

  // Next-state logic for the pixel FSM and its counters.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    pix_cnt_nx = pix_cnt;
`ifdef LED_DRV_LATCH_EN
    lat_cnt_nx  = lat_cnt;
    row_addr_nx = row_addr_out;
    row_done_nx = 1'b0;
`endif
    case (state)
      SS_IDLE: begin
        if (accept_c) begin
          state_nx   = SS_SHIFT;
          bit_cnt_nx = '0;
        end
      end
      SS_SHIFT: begin
        if (fall_c) begin
          if (bit_cnt == BIT_W'(COLOR_DEPTH - 1)) begin
            bit_cnt_nx = '0;
            pix_cnt_nx = row_end_c ? '0 : pix_cnt + PIX_W'(1);
`ifdef LED_DRV_LATCH_EN
            state_nx   = row_end_c ? SS_LATCH : SS_IDLE;
            lat_cnt_nx = '0;
`else
            state_nx   = SS_IDLE;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef LED_DRV_LATCH_EN
      SS_LATCH: begin
        if (lat_cnt == LAT_W'(LATCH_CYCLES - 1)) begin
          state_nx    = SS_IDLE;
          lat_cnt_nx  = '0;
          row_done_nx = 1'b1;
          row_addr_nx = (row_addr_out == ADDR_W'(NUM_ROWS - 1)) ? '0
                                                                 : row_addr_out + ADDR_W'(1);
        end else begin
          lat_cnt_nx = lat_cnt + LAT_W'(1);
        end
      end
`endif
      default: state_nx = SS_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state   <= SS_IDLE;
      started <= 1'b0;
      bit_cnt <= '0;
      pix_cnt <= '0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      bit_cnt <= bit_cnt_nx;
      pix_cnt <= pix_cnt_nx;
    end
  end

`ifdef LED_DRV_LATCH_EN
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      lat_cnt      <= '0;
      row_addr_out <= '0;
      latch_out    <= 1'b0;
      row_done_out <= 1'b0;
    end else begin
      lat_cnt      <= lat_cnt_nx;
      row_addr_out <= row_addr_nx;
      latch_out    <= (state_nx == SS_LATCH);
      row_done_out <= row_done_nx;
    end
  end
`else
  // Rows are sequenced externally in this build.
  assign latch_out    = 1'b0;
  assign row_done_out = 1'b0;
  assign row_addr_out = '0;
`endif

endmodule
